// File: rtl/misc_pkg.sv
// rtl/misc_pkg.sv - shared fetch-stage constants, state encoding and entry type
package misc_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_STEP   = 16'd2;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // One buffered fetch: the address it came from and the word returned.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps 16'hFFFE to 16'h0000, bit0 carried.
  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory request/response bus
interface if_fetch_unit_if;

  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemReady;
  logic        IMemValid;
  logic [15:0] IMemData;

  // Fetch unit side: issues requests, consumes read data.
  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemReady,
    input  IMemValid,
    input  IMemData
  );

  // Memory side: accepts requests, returns read data.
  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemReady,
    output IMemValid,
    output IMemData
  );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// rtl/if_fetch_unit_fifo.sv - small circular fetch buffer of {pc, ir} entries
module if_fetch_fifo
  import misc_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // A full buffer still takes a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Register buffer state; reset empties it and clears stale words.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, memory requests, buffer, IF/ID feed
module if_fetch_unit
  import misc_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Redirect,
  input  logic [15:0]           RedirectPC,
  if_fetch_unit_if.master       imem,
  output logic [15:0]           OPC,
  output logic [15:0]           OPCP2,
  output logic [15:0]           OIR,
  output logic                  OValid,
  output logic                  IFIDWrite
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      req_pc_q, req_pc_d;

  logic             accept;
  logic             fifo_push;
  logic             fifo_pop;
  fetch_entry_t     fifo_push_data;
  fetch_entry_t     fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  // Request only when a returned word is guaranteed a buffer slot; held low
  // while Reset is asserted so the first request follows its release.
  assign imem.IMemReq  = (state_q == REQ) && (fifo_count < CNT_W'(FIFO_DEPTH)) && !Reset;
  assign imem.IMemAddr = pc_q;
  assign accept        = imem.IMemReq && imem.IMemReady;

  assign IFIDWrite = !Stall || Redirect;
  assign OValid    = !fifo_empty;
  assign fifo_pop  = IFIDWrite && OValid && !Redirect;

  // Fetch sequencing: next state, PC advance, response capture and redirect.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    fifo_push      = 1'b0;
    fifo_push_data = '{pc: req_pc_q, ir: imem.IMemData};
    if (Redirect) begin
      pc_d = RedirectPC;
      // A request still outstanding after this cycle must have its response
      // thrown away. One that completes in the redirect cycle itself is
      // already gone, so waiting for it in DROP would never finish.
      if (state_q == REQ) begin
        state_d = accept ? DROP : REQ;
      end else begin
        state_d = imem.IMemValid ? REQ : DROP;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (accept) begin
            state_d  = WAIT;
            req_pc_d = pc_q;
            pc_d     = pc_next(pc_q);
          end
        end
        WAIT: begin
          if (imem.IMemValid) begin
            fifo_push = !fifo_full || fifo_pop;
            state_d   = REQ;
          end
        end
        DROP: begin
          if (imem.IMemValid) begin
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // Fetch FSM, fetch PC and address of the request in flight.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Present the buffer head, or a NOP bubble when empty or squashing.
  always_comb begin
    OPC   = '0;
    OPCP2 = '0;
    OIR   = NOP_INSTR;
    if (!Redirect && !fifo_empty) begin
      OPC   = fifo_head.pc;
      OPCP2 = pc_next(fifo_head.pc);
      OIR   = fifo_head.ir;
    end
  end

  if_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .reset    (Reset),
    .push     (fifo_push),
    .push_data(fifo_push_data),
    .pop      (fifo_pop),
    .flush    (Redirect),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit against a program-order model
module tb_if_fetch_unit;

  localparam logic [15:0] RST_PC = 16'hFFFE;
  localparam logic [15:0] SCRAM  = 16'hA5A5;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic [15:0] OPC;
  logic [15:0] OPCP2;
  logic [15:0] OIR;
  logic        OValid;
  logic        IFIDWrite;

  if_fetch_unit_if imem ();

  if_fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(2)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .imem      (imem),
    .OPC       (OPC),
    .OPCP2     (OPCP2),
    .OIR       (OIR),
    .OValid    (OValid),
    .IFIDWrite (IFIDWrite)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_capt = 0;
  bit zero_wait = 1'b1;

  // Expected program-order fetch addresses since the last reset/redirect.
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void restart(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(start + 16'(2 * i));
    end
  endfunction

  // Memory model: one request at a time, data = address ^ A5A5.
  initial begin
    logic        mem_pending;
    logic [15:0] mem_addr;
    int          mem_dly;
    mem_pending = 1'b0;
    mem_addr    = '0;
    mem_dly     = 0;
    imem.IMemReady = 1'b0;
    imem.IMemValid = 1'b0;
    imem.IMemData  = '0;
    forever begin
      @(posedge CLK);
      #1;
      imem.IMemValid = 1'b0;
      if (mem_pending) begin
        if (mem_dly == 0) begin
          imem.IMemValid = 1'b1;
          imem.IMemData  = mem_addr ^ SCRAM;
          mem_pending    = 1'b0;
        end else begin
          mem_dly--;
        end
      end
      imem.IMemReady = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      if (Reset) begin
        mem_pending = 1'b0;
      end else if (imem.IMemReq && imem.IMemReady) begin
        if (mem_pending) chk("one_outstanding", 48'd1, 48'd0);
        mem_pending = 1'b1;
        mem_addr    = imem.IMemAddr;
        mem_dly     = zero_wait ? 0 : int'($urandom_range(0, 2));
      end
    end
  end

  // Monitor: checks every presented slot and each IF/ID capture.
  initial begin
    logic        prev_hold;
    logic [15:0] prev_pc;
    logic [15:0] prev_ir;
    logic [15:0] e;
    prev_hold = 1'b0;
    prev_pc   = '0;
    prev_ir   = '0;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        prev_hold = 1'b0;
      end else begin
        chk("ifid_write", 48'(IFIDWrite), 48'(!Stall || Redirect));
        if (Redirect) begin
          chk("squash_slot", {OPC, OPCP2, OIR}, 48'h0);
        end else if (!OValid) begin
          chk("empty_slot", {OPC, OPCP2, OIR}, 48'h0);
        end else if (prev_hold) begin
          chk("stall_hold", 48'({OPC, OIR}), 48'({prev_pc, prev_ir}));
        end
        if (IFIDWrite && OValid && !Redirect) begin
          if (exp_q.size() == 0) begin
            chk("exp_underflow", 48'd1, 48'd0);
          end else begin
            e = exp_q.pop_front();
            chk("capture", {OPC, OPCP2, OIR}, {e, 16'(e + 16'd2), 16'(e ^ SCRAM)});
            n_capt++;
          end
        end
        prev_hold = Stall && !Redirect && OValid;
        prev_pc   = OPC;
        prev_ir   = OIR;
      end
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic rd, input logic [15:0] tgt);
    @(posedge CLK);
    #1;
    Reset      = rst;
    Stall      = st;
    Redirect   = rd;
    RedirectPC = tgt;
    if (rst) restart(RST_PC);
    else if (rd) restart(tgt);
    @(negedge CLK);
  endtask

  // Stimulus: directed scenarios, then randomized stalls/redirects/resets.
  initial begin
    bit found;
    int since;
    logic rst, st, rd;
    Reset      = 1'b1;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    restart(RST_PC);

    // Reset held two cycles, then first request at RESET_PC.
    cyc(1, 0, 0, 16'h0);
    cyc(1, 0, 0, 16'h0);
    chk("rst_ovalid", 48'(OValid), 48'd0);
    chk("rst_oir", 48'(OIR), 48'h0);
    chk("rst_req", 48'(imem.IMemReq), 48'd0);
    cyc(0, 0, 0, 16'h0);
    chk("first_req", 48'({imem.IMemReq, imem.IMemAddr}), 48'({1'b1, RST_PC}));
    // Stream across the FFFE -> 0000 wrap with zero-wait memory.
    repeat (20) cyc(0, 0, 0, 16'h0);

    // Zero-wait stream from 0x0100.
    cyc(0, 0, 1, 16'h0100);
    repeat (30) cyc(0, 0, 0, 16'h0);

    // Stall long enough to fill the buffer; requests must stop.
    repeat (6) cyc(0, 1, 0, 16'h0);
    chk("full_no_req", 48'({imem.IMemReq, OValid}), 48'({1'b0, 1'b1}));
    repeat (10) cyc(0, 0, 0, 16'h0);

    // Redirect in the WAIT cycle; its response must be discarded.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 0, 16'h0);
      found = imem.IMemReq && imem.IMemReady;
    end
    chk("wait_reached", 48'(found), 48'd1);
    cyc(0, 0, 1, 16'h0200);
    cyc(0, 0, 0, 16'h0);
    chk("redir_addr", 48'({imem.IMemReq, imem.IMemAddr}), 48'({1'b1, 16'h0200}));
    repeat (20) cyc(0, 0, 0, 16'h0);

    // Reset while waiting with one buffered entry.
    cyc(1, 1, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    chk("one_buffered_accept", 48'({OValid, imem.IMemReq, imem.IMemReady}), 48'({1'b1, 1'b1, 1'b1}));
    cyc(1, 1, 0, 16'h0);
    chk("wait_one_entry", 48'(OValid), 48'd1);
    cyc(0, 1, 0, 16'h0);
    chk("reset_flush", 48'(OValid), 48'd0);
    chk("post_reset_addr", 48'({imem.IMemReq, imem.IMemAddr}), 48'({1'b1, RST_PC}));

    // Randomized traffic with variable memory latency.
    zero_wait = 1'b0;
    since     = 0;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 9) < 3);
      rd  = !rst && (($urandom_range(0, 29) == 0) || since >= 100);
      since = (rst || rd) ? 0 : since + 1;
      cyc(rst, st, rd, 16'($urandom));
    end
    cyc(0, 0, 0, 16'h0);
    chk("liveness", 48'(n_capt >= 150), 48'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
